// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, keeps at most one instruction-memory
// request outstanding, and feeds decode through a stallable IF/ID register
// with a one-entry skid buffer. Branch/jump redirects from EX flush the front end.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        brn_en,
  input  logic        jump,
  input  logic [31:0] target,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic        flush
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic        skid_valid_q, skid_valid_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc_q, skid_pc_d;

  logic redirect;
  logic resp;

  assign redirect  = brn_en | jump;
  // A response only counts when it belongs to a live (non-dropped) request.
  assign resp      = (state_q == S_WAIT) & imem_rvalid;

  assign flush     = redirect & ~rst;
  assign imem_req  = ~rst & (state_q == S_REQ) & ~skid_valid_q & ~redirect;
  assign imem_addr = pc_q;
  assign id_valid  = id_valid_q;
  assign id_instr  = id_instr_q;
  assign id_pc     = id_pc_q;

  // State, PC and IF/ID/skid registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      req_pc_q     <= '0;
      id_valid_q   <= 1'b0;
      id_instr_q   <= NOP_INSTR;
      id_pc_q      <= '0;
      skid_valid_q <= 1'b0;
      skid_instr_q <= NOP_INSTR;
      skid_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_pc_q     <= req_pc_d;
      id_valid_q   <= id_valid_d;
      id_instr_q   <= id_instr_d;
      id_pc_q      <= id_pc_d;
      skid_valid_q <= skid_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

  // Next-state: request FSM, PC update, IF/ID advance and skid capture.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_pc_d     = req_pc_q;
    id_valid_d   = id_valid_q;
    id_instr_d   = id_instr_q;
    id_pc_d      = id_pc_q;
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;

    if (redirect) begin
      pc_d         = target & 32'hFFFF_FFFC;
      id_valid_d   = 1'b0;
      id_instr_d   = NOP_INSTR;
      skid_valid_d = 1'b0;
      // With a request in flight, a same-cycle rvalid retires it here;
      // otherwise the stale response must still be swallowed in DROP.
      case (state_q)
        S_WAIT, S_DROP: state_d = imem_rvalid ? S_REQ : S_DROP;
        default:        state_d = S_REQ;
      endcase
    end else begin
      case (state_q)
        S_REQ: begin
          if (imem_req && imem_gnt) begin
            pc_d     = pc_q + 32'd4;
            req_pc_d = pc_q;
            state_d  = S_WAIT;
          end
        end
        S_WAIT, S_DROP: begin
          if (imem_rvalid) state_d = S_REQ;
        end
        default: state_d = S_REQ;
      endcase

      if (!stall) begin
        if (skid_valid_q) begin
          id_valid_d   = 1'b1;
          id_instr_d   = skid_instr_q;
          id_pc_d      = skid_pc_q;
          skid_valid_d = resp;
          if (resp) begin
            skid_instr_d = imem_rdata;
            skid_pc_d    = req_pc_q;
          end
        end else if (resp) begin
          id_valid_d = 1'b1;
          id_instr_d = imem_rdata;
          id_pc_d    = req_pc_q;
        end else begin
          id_valid_d = 1'b0;
        end
      end else if (resp) begin
        if (!id_valid_q) begin
          id_valid_d = 1'b1;
          id_instr_d = imem_rdata;
          id_pc_d    = req_pc_q;
        end else begin
          skid_valid_d = 1'b1;
          skid_instr_d = imem_rdata;
          skid_pc_d    = req_pc_q;
        end
      end
    end
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the RISC-V pipeline. It owns the program counter, issues one-at-a-time requests to instruction memory, and hands fetched words to decode through a stallable IF/ID output register backed by a one-entry skid buffer. It consumes the taken-branch decision (`brn_en`) and jump indication from the execute-stage branch logic and redirects the PC. It also raises `flush` so the pipeline kills wrong-path instructions.

## Interface
- `RESET_PC`, 32'h0000_0000: PC fetched first after reset.
- `NOP_INSTR`, 32'h0000_0013: value of `id_instr` when empty or reset (`addi x0,x0,0`).
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `brn_en`  in  1  conditional branch taken (EX stage).
- `jump`  in  1  JAL/JALR in EX, unconditional redirect.
- `target`  in  32  redirect address; bits [1:0] forced to 0 internally.
- `stall`  in  1  decode cannot accept; IF/ID holds.
- `imem_req`  out  1  request valid.
- `imem_addr`  out  32  request address (= PC register).
- `imem_gnt`  in  1  request accepted this cycle.
- `imem_rvalid`  in  1  response valid; in order, ≥1 cycle after grant.
- `imem_rdata`  in  32  instruction word.
- `id_valid`  out  1  IF/ID holds a valid instruction.
- `id_instr`  out  32  instruction to decode.
- `id_pc`  out  32  PC of `id_instr`.
- `flush`  out  1  kill IF/ID and ID/EX contents.

## Operation
- `redirect = brn_en | jump`. `flush = redirect`, combinational, same cycle.
- Redirect beats `stall`.
- FSM states:
  - REQ: may issue a request.
  - WAIT: one request outstanding.
  - DROP: outstanding response must be discarded.
- `imem_req = (state==REQ) & !skid_valid & !redirect`. The request may drop without a grant.
- Only one request is ever outstanding.
- REQ:
  - With `imem_req & imem_gnt`: PC += 4 (modulo 2^32, so 32'hFFFF_FFFC wraps to 0). Record the request PC and go to WAIT.
  - With `redirect & imem_gnt`: cannot occur, because `req=0`.
- WAIT with `imem_rvalid`, no redirect, goes to REQ. Capture the response:
  - IF/ID empty, or `!stall`: the response enters IF/ID.
  - IF/ID valid and `stall`: the response enters the skid buffer.
- WAIT with redirect:
  - Same-cycle `rvalid`: discard the response and go to REQ.
  - Otherwise: go to DROP.
- DROP: on `imem_rvalid`, discard the response and go to REQ. A redirect in DROP updates the PC and the state stays DROP.
- Any redirect, at the clock edge:
  - PC <= {target[31:2],2'b00}.
  - `id_valid` <= 0 and `id_instr` <= NOP_INSTR.
  - The skid buffer is cleared.
- IF/ID advance when `!stall` and no redirect, in priority order:
  - Skid valid: skid moves to IF/ID. The skid is freed, or refilled the same cycle by a simultaneous `rvalid`.
  - Else if `rvalid` in WAIT: the response goes to IF/ID.
  - Else: `id_valid` <= 0.
- Stall with `id_valid=1`: `id_instr` and `id_pc` hold.
- Reset values: PC = RESET_PC; state = REQ; `id_valid` = 0; `id_instr` = NOP_INSTR; `id_pc` = 0; skid empty.
- Output values while `rst` is high: `imem_req` = 0 and `flush` = 0. `flush` is 0 in reset even if `brn_en` or `jump` is asserted.
- Reset mid-transaction abandons any outstanding response. Memory is reset on the same `rst`.

## Timing
- First `imem_req` (addr RESET_PC) comes in the first cycle after `rst` deasserts.
- Fetch-to-decode latency: grant in cycle N, `rvalid` at N+k (k≥1), `id_valid` at N+k+1.
- Throughput with a 1-cycle memory: one instruction per 2 cycles (single outstanding request).
- Redirect in cycle N:
  - `flush` is high in N only.
  - New-target request at N+1 if state is REQ or WAIT+rvalid.
  - Otherwise, new-target request the cycle after the dropped `rvalid`.
- Skid full blocks requests. Requests resume the cycle after decode drains the skid.

## Test plan
- Reset release, RESET_PC=0, 1-cycle memory returning `addr|0xA000_0000`: requests go to 0,4,8. `id_pc`/`id_instr` = 0/0xA000_0000, then 4/0xA000_0004, with `id_valid` every other cycle.
- Redirect in WAIT: target=0x0000_0103 asserted the cycle after grant of addr 8.
  - `flush` pulses.
  - The response for 8 is discarded and never reaches IF/ID.
  - The next request is addr 0x100.
  - `id_valid`=0 after the flush.
- Redirect coincident with `rvalid`: the response is dropped and state returns directly to REQ. The request to the target is issued next cycle with no DROP wait.
- Stall for 4 cycles with `id_valid`=1:
  - IF/ID holds.
  - The next response lands in the skid.
  - `imem_req` stays 0.
  - On release, the skid word appears in IF/ID the next cycle and a request issues the same cycle.
- PC wrap: RESET_PC=32'hFFFF_FFFC. The first request is 0xFFFF_FFFC and the second is 0x0000_0000.
- Async reset asserted mid-WAIT:
  - Outputs take reset values immediately, with no clock edge.
  - The late `rvalid` during reset is ignored.
  - Fetch restarts at RESET_PC.
